// File: rtl/rca_config.sv
// RCA configuration: LSQ depth default, queue entry and FSM state types,
// plus store lane helpers (byte enables and lane-replicated write data).
package rca_config;

    import riscv_types::*;

    localparam int LSQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            is_load;
    } lsq_entry_t;

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } lsq_state_t;

    // size is fn3[1:0]: 00 byte, 01 half, else word
    function automatic logic [3:0] store_be(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'hF;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(
        input logic [1:0]      size,
        input logic [XLEN-1:0] d
    );
        logic [XLEN-1:0] w;
        w = d;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/riscv_types.sv
// Shared RISC-V type definitions: XLEN and the load/store funct3 encodings.
// Imported by the RCA configuration package and the LSQ datapath.
package riscv_types;

    localparam int XLEN = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

endpackage

// File: rtl/rca_lsq_ld_align.sv
// Load result extraction: picks the byte/halfword at the given offset
// and zero/sign extends per fn3.
// Ports: i_rdata (word), i_off (addr[1:0]), i_fn3 -> o_result.
module rca_lsq_ld_align
    import riscv_types::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_fn3,
    output logic [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        unique case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
        // halfword select ignores the misaligned low bit
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_result = i_rdata;
        case (i_fn3)
            LS_B:    o_result = {{24{w_byte[7]}}, w_byte};
            LS_H:    o_result = {{16{w_half[15]}}, w_half};
            LS_BU:   o_result = {24'h0, w_byte};
            LS_HU:   o_result = {16'h0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/rca_ou_lsq.sv
// In-order load/store queue between the RCA OU grid and the data memory
// bus; one outstanding transaction, loads returned aligned and extended.
// Ports: clk/rst (sync, active high); OU side addr/data/fn3/load/store/
// new_request -> lsq_full, load_data, load_complete; memory side
// mem_addr/wdata/be/rd/wr/req_valid <- mem_req_ready/rdata/rvalid.
// Option: define RCA_LSQ_BYPASS_EN to let a request hit the bus in the
// same cycle it arrives when the queue is empty and idle.
module rca_ou_lsq
    import riscv_types::*;
    import rca_config::*;
#(
    parameter int DEPTH = LSQ_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic            new_request,
    output logic            lsq_full,
    output logic [XLEN-1:0] load_data,
    output logic            load_complete,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    lsq_entry_t      r_fifo [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    lsq_state_t      r_state;
    logic [XLEN-1:0] r_load_data;
    logic            r_load_complete;
    logic [1:0]      r_ld_off;
    logic [2:0]      r_ld_fn3;
    logic            r_pop_pend;

    lsq_entry_t      w_new;
    lsq_entry_t      w_req;
    lsq_state_t      w_state_nxt;
    logic            w_push;
    logic            w_fifo_wr;
    logic            w_pop;
    logic            w_req_valid;
    logic            w_from_fifo;
    logic            w_issue_ld;
    logic            w_ld_done;
    logic [XLEN-1:0] w_ld_res;

    // load==store==0 is illegal; it falls through as a store
    assign w_new = '{addr: addr, data: data, fn3: fn3,
                     is_load: load && !store};

    assign lsq_full = (r_count == FULL_CNT);
    assign w_push   = new_request && !lsq_full;

`ifdef RCA_LSQ_BYPASS_EN
    logic w_byp;
    assign w_byp = new_request && (r_count == '0) && (r_state == IDLE);
    assign w_req = w_byp ? w_new : r_fifo[r_head];
    assign w_req_valid = (r_state == IDLE) &&
                         (w_byp || (r_count != '0));
    assign w_from_fifo = !w_byp;
    // a bypassed request that the bus takes never occupies a slot
    assign w_fifo_wr = w_push && !(w_byp && mem_req_ready);
`else
    assign w_req       = r_fifo[r_head];
    assign w_req_valid = (r_state == IDLE) && (r_count != '0);
    assign w_from_fifo = 1'b1;
    assign w_fifo_wr   = w_push;
`endif

    assign w_ld_done = (r_state == WAIT_RESP) && mem_rvalid;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue_ld  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req_valid && mem_req_ready) begin
                    if (w_req.is_load) begin
                        w_state_nxt = WAIT_RESP;
                        w_issue_ld  = 1'b1;
                    end else begin
                        w_pop = w_from_fifo;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = IDLE;
                    w_pop       = r_pop_pend;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo[r_tail] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_state         <= IDLE;
            r_load_data     <= '0;
            r_load_complete <= 1'b0;
            r_ld_off        <= '0;
            r_ld_fn3        <= '0;
            r_pop_pend      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_load_complete <= w_ld_done;
            if (w_fifo_wr) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            unique case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // the response arrives later, so keep how to align it
            if (w_issue_ld) begin
                r_ld_off   <= w_req.addr[1:0];
                r_ld_fn3   <= w_req.fn3;
                r_pop_pend <= w_from_fifo;
            end
            if (w_ld_done) begin
                r_load_data <= w_ld_res;
            end
        end
    end

    rca_lsq_ld_align u_ld_align (
        .i_rdata  (mem_rdata),
        .i_off    (r_ld_off),
        .i_fn3    (r_ld_fn3),
        .o_result (w_ld_res)
    );

    assign mem_req_valid = w_req_valid;
    assign mem_rd        = w_req_valid && w_req.is_load;
    assign mem_wr        = w_req_valid && !w_req.is_load;
    assign mem_addr      = {w_req.addr[XLEN-1:2], 2'b00};
    assign mem_be        = w_req.is_load ? 4'hF :
                           store_be(w_req.fn3[1:0], w_req.addr[1:0]);
    assign mem_wdata     = store_wdata(w_req.fn3[1:0], w_req.data);
    assign load_data     = r_load_data;
    assign load_complete = r_load_complete;

`ifndef SYNTHESIS
    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(new_request && lsq_full))
        else $warning("rca_ou_lsq: request dropped, queue full");
    a_ld_st: assert property (@(posedge clk) disable iff (rst)
        !(new_request && (load == store)))
        else $warning("rca_ou_lsq: load and store flags not exclusive");
`endif

endmodule

// File: tb/tb_rca_ou_lsq.sv
// Directed bench for rca_ou_lsq: store/load lanes, extraction,
// full queue ordering, reset mid-operation, issue latency.
module tb_rca_ou_lsq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data, mem_rdata;
    logic [2:0]  fn3;
    logic        load, store, new_request;
    logic        mem_req_ready, mem_rvalid;
    logic        lsq_full, load_complete;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd, mem_wr, mem_req_valid;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rca_ou_lsq dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .data          (data),
        .fn3           (fn3),
        .load          (load),
        .store         (store),
        .new_request   (new_request),
        .lsq_full      (lsq_full),
        .load_data     (load_data),
        .load_complete (load_complete),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic ld);
        new_request = 1'b1;
        addr = a;
        data = d;
        fn3 = f;
        load = ld;
        store = !ld;
    endtask

    task automatic idle_req();
        new_request = 1'b0;
        load = 1'b0;
        store = 1'b0;
    endtask

    // push, issue and complete one load with ready held high
    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic [2:0] f, input logic [31:0] rd,
                           input logic [31:0] exp);
        mem_req_ready = 1'b1;
        req(a, 32'h0, f, 1'b1);
        step();
        idle_req();
        step();
        mem_req_ready = 1'b0;
        mem_rdata = rd;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk({tag, "_cmp"}, {31'h0, load_complete}, 32'h1);
        chk({tag, "_data"}, load_data, exp);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a,
                            input logic [2:0] f, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] wd);
        mem_req_ready = 1'b0;
        req(a, d, f, 1'b0);
        step();
        idle_req();
        chk({tag, "_wr"}, {31'h0, mem_wr}, 32'h1);
        chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, be});
        chk({tag, "_wd"}, mem_wdata, wd);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk({tag, "_done"}, {31'h0, mem_req_valid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        addr = '0; data = '0; fn3 = '0;
        load = 1'b0; store = 1'b0; new_request = 1'b0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_full", {31'h0, lsq_full}, 32'h0);
        chk("rst_cmp", {31'h0, load_complete}, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_vld", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_rdwr", {30'h0, mem_rd, mem_wr}, 32'h0);
        rst = 1'b0;
        step();

        // SW then LW at 0x100
        do_store("sw", 32'h100, 3'b010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
        req(32'h100, 32'h0, 3'b010, 1'b1);
        step();
        idle_req();
        chk("lw_rd", {31'h0, mem_rd}, 32'h1);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_be", {28'h0, mem_be}, 32'hF);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("lw_wait", {31'h0, mem_req_valid}, 32'h0);
        mem_rdata = 32'hDEADBEEF;
        mem_rvalid = 1'b1;
        chk("lw_early", {31'h0, load_complete}, 32'h0);
        step();
        mem_rvalid = 1'b0;
        chk("lw_cmp", {31'h0, load_complete}, 32'h1);
        chk("lw_data", load_data, 32'hDEADBEEF);
        step();
        chk("lw_pulse", {31'h0, load_complete}, 32'h0);
        chk("lw_hold", load_data, 32'hDEADBEEF);

        // extraction and extension
        do_load("lb", 32'h103, 3'b000, 32'h80FF0000, 32'hFFFFFF80);
        do_load("lbu", 32'h103, 3'b100, 32'h80FF0000, 32'h00000080);
        do_load("lh", 32'h102, 3'b001, 32'h80FF0000, 32'hFFFF80FF);
        do_load("lhu", 32'h102, 3'b101, 32'h80FF0000, 32'h000080FF);
        do_load("lb2", 32'h102, 3'b000, 32'h80FF0000, 32'hFFFFFFFF);
        do_load("lhmis", 32'h101, 3'b001, 32'h1234F678, 32'hFFFFF678);

        // store lanes
        do_store("sb", 32'h101, 3'b000, 32'h12, 4'b0010, 32'h12121212);
        do_store("sh", 32'h102, 3'b001, 32'hABCD, 4'b1100, 32'hABCDABCD);
        do_store("shmis", 32'h103, 3'b001, 32'h5A5A, 4'b1100, 32'h5A5A5A5A);
        do_store("swmis", 32'h102, 3'b010, 32'h01020304, 4'hF, 32'h01020304);

        // fill with ready low, drop a fifth, drain in order
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_pre%0d", i), {31'h0, lsq_full}, 32'h0);
            req(32'(i * 4), 32'h0, 3'b010, 1'b1);
            step();
        end
        chk("full_4", {31'h0, lsq_full}, 32'h1);
        req(32'h10, 32'h0, 3'b010, 1'b1);
        step();
        idle_req();
        chk("full_5", {31'h0, lsq_full}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_v%0d", i), {31'h0, mem_req_valid}, 32'h1);
            chk($sformatf("drain_a%0d", i), mem_addr, 32'(i * 4));
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            mem_rdata = 32'h1000 + 32'(i);
            mem_rvalid = 1'b1;
            step();
            mem_rvalid = 1'b0;
            chk($sformatf("drain_c%0d", i), {31'h0, load_complete}, 32'h1);
            chk($sformatf("drain_d%0d", i), load_data, 32'h1000 + 32'(i));
            chk($sformatf("drain_f%0d", i), {31'h0, lsq_full}, 32'h0);
        end
        chk("drain_empty", {31'h0, mem_req_valid}, 32'h0);

        // reset while waiting for a response
        mem_req_ready = 1'b1;
        req(32'h200, 32'h0, 3'b010, 1'b1);
        step();
        idle_req();
        step();
        mem_req_ready = 1'b0;
        chk("rmo_wait", {31'h0, mem_req_valid}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        mem_rdata = 32'h55;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("rmo_cmp", {31'h0, load_complete}, 32'h0);
        chk("rmo_full", {31'h0, lsq_full}, 32'h0);
        chk("rmo_vld", {31'h0, mem_req_valid}, 32'h0);
        chk("rmo_ld", load_data, 32'h0);
        step();
        chk("rmo_cmp2", {31'h0, load_complete}, 32'h0);

        // issue latency from an empty idle queue
        mem_req_ready = 1'b1;
        req(32'h300, 32'h0, 3'b010, 1'b1);
        #1;
`ifdef RCA_LSQ_BYPASS_EN
        chk("lat_t0", {31'h0, mem_req_valid}, 32'h1);
        step();
        idle_req();
        chk("lat_t1", {31'h0, mem_req_valid}, 32'h0);
`else
        chk("lat_t0", {31'h0, mem_req_valid}, 32'h0);
        step();
        idle_req();
        chk("lat_t1", {31'h0, mem_req_valid}, 32'h1);
        step();
`endif
        mem_req_ready = 1'b0;
        mem_rdata = 32'hCAFE0001;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("lat_cmp", {31'h0, load_complete}, 32'h1);
        chk("lat_data", load_data, 32'hCAFE0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rca_ou_lsq.md
Name: rca_ou_lsq

Overview:
Load/store queue that services the LSQ request interface driven by RCA memory operating units (OUs). It accepts load/store requests from one OU port and buffers them in an in-order FIFO. Requests are issued one at a time to a simple word-wide memory bus. Load results are returned byte/halfword-extracted and zero- or sign-extended per fn3. It sits between the reconfigurable OU grid and the data-memory arbiter.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  XLEN  request byte address from OU
data  in  XLEN  store data from OU (ignored for loads)
fn3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
load  in  1  request is a load
store  in  1  request is a store
new_request  in  1  request valid
lsq_full  out  1  queue cannot accept a request this cycle
load_data  out  XLEN  extracted/extended load result
load_complete  out  1  one-cycle pulse: load_data valid
mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
mem_wdata  out  XLEN  store data replicated into lanes
mem_be  out  4  byte enables
mem_rd  out  1  read request
mem_wr  out  1  write request
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_rdata  in  XLEN  read data
mem_rvalid  in  1  read data valid

Behaviour:
- Reset: FIFO count and pointers 0, state IDLE; lsq_full=0, load_complete=0, load_data=0, mem_req_valid=0, mem_rd=0, mem_wr=0.
- Push: new_request && !lsq_full. Captures {addr, data, fn3, load} into the tail. new_request while lsq_full is dropped and flagged by assertion.
- new_request with load==store is illegal and flagged by assertion; the entry is treated as a store if store=1.
- lsq_full = (count==DEPTH), combinational from registered count. A pop in the same cycle does not free a slot for a push.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- FSM, IDLE:
  - mem_req_valid = (count!=0); the head entry drives mem_*.
  - On mem_req_valid && mem_req_ready with a store: pop and stay IDLE.
  - With a load: go to WAIT_RESP; do not pop yet.
- FSM, WAIT_RESP:
  - mem_req_valid=0.
  - On mem_rvalid: pop the head, register the extracted result into load_data, pulse load_complete the next cycle, return to IDLE.
- Only one memory transaction is outstanding at a time. Completion order equals request order.
- mem_rvalid in IDLE is ignored. This covers a stale response after a reset mid-operation.
- Store lanes (o = addr[1:0]):
  - SB: wdata = {4{data[7:0]}}, be = 1<<o.
  - SH: wdata = {2{data[15:0]}}, be = 2'b11<<o.
  - SW: wdata = data, be = 4'hF.
  - Loads drive be = 4'hF.
- Load extract: select the byte at o or the halfword at o[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned LH/LW/SH/SW: address bits below the access size are ignored, with no trap.
- load_data holds its value until the next load completes.
- Latency, empty queue, IDLE, ready=1, no bypass:
  - push at T, mem_req_valid at T+1.
  - mem_rvalid at T+1+N gives load_complete at T+2+N.

Optional Feature:
RCA_LSQ_BYPASS_EN
- Defined: when count==0 and state is IDLE, an accepted new_request drives mem_* combinationally in the same cycle.
  - If mem_req_ready is high, the FIFO is not written. A load enters WAIT_RESP directly; a store completes immediately.
  - If ready is low, the request is pushed normally.
  - Saves one cycle.
- Undefined: all requests pass through the FIFO, and mem_* are driven from registered head state only.

Decomposition:
- Package rca_config holds:
  - LSQ_DEPTH default.
  - lsq_entry_t struct {addr, data, fn3, is_load}.
  - lsq_state_t enum {IDLE, WAIT_RESP}.
- Existing riscv_types LS_* fn3 constants are reused.
- One sub-module: rca_lsq_ld_align, combinational load extraction and extension (rdata, offset, fn3 -> result).

Test Plan:
- Store then load: SW addr=0x100 data=0xDEADBEEF, then LW 0x100 -> mem_be=F, wdata=0xDEADBEEF; load_data=0xDEADBEEF, one load_complete pulse.
- Byte lanes: LB at 0x103 with rdata=0x80FF_0000 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- Store lanes: SB 0x101 data=0x12 -> be=0010, wdata=0x12121212; SH 0x102 data=0xABCD -> be=1100, wdata=0xABCDABCD.
- Full: hold mem_req_ready=0 and push 4 loads -> lsq_full=1 after the 4th. A 5th new_request is dropped. Release ready -> 4 in-order completions with addresses 0x0,0x4,0x8,0xC.
- Reset mid-op: assert rst in WAIT_RESP, then mem_rvalid=1 one cycle after rst deasserts -> no load_complete, count=0, lsq_full=0.
- Bypass (RCA_LSQ_BYPASS_EN, ready=1, empty): LW pushed at T -> mem_req_valid=1 at T. Without the macro -> mem_req_valid=1 at T+1.
